adder_accum: RTL and testbench

ADDER_ACCUM -- requirements
Module: adder_accum

---
 rtl/adder_accum_pkg.sv | 10 +
 rtl/struc_adder.sv | 22 ++
 rtl/adder_accum.sv | 94 +++++++++
 tb/tb_adder_accum.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_accum_pkg.sv
// Shared definitions for the adder_accum block: FSM state encoding.
package adder_accum_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/struc_adder.sv
// Ripple-carry adder built from per-bit full-adder equations.
module struc_adder #(
    parameter int unsigned SIZE = 4
) (
    input  logic [SIZE-1:0] dinx_i,
    input  logic [SIZE-1:0] diny_i,
    output logic [SIZE-1:0] sum_o,
    output logic            cout_o
);

    logic [SIZE:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < SIZE; i++) begin : g_fa
        assign sum_o[i]     = dinx_i[i] ^ diny_i[i] ^ carry[i];
        assign carry[i + 1] = (dinx_i[i] & diny_i[i]) | (carry[i] & (dinx_i[i] ^ diny_i[i]));
    end

    assign cout_o = carry[SIZE];

endmodule

// File: rtl/adder_accum.sv
// Sums count_i terms presented on a valid/ready input and holds the result
// (with a sticky carry-out flag) on a valid/ready output until taken.
module adder_accum
    import adder_accum_pkg::*;
#(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             in_valid_i,
    input  logic [SIZE-1:0]  in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [SIZE-1:0]  sum_o,
    output logic             ovf_o,
    output logic             busy_o
);

    state_e           state_q, state_d;
    logic [SIZE-1:0]  acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    logic [SIZE-1:0]  add_sum;
    logic             add_cout;

    struc_adder #(
        .SIZE (SIZE)
    ) u_adder (
        .dinx_i (acc_q),
        .diny_i (in_data_i),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        rem_d   = rem_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    rem_d   = count_i;
                    state_d = (count_i == '0) ? StDone : StAccum;
                end
            end
            StAccum: begin
                // in_ready_o is implied by being in this state
                if (in_valid_i) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | add_cout;
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            rem_q   <= rem_d;
        end
    end

    assign in_ready_o  = (state_q == StAccum);
    assign out_valid_o = (state_q == StDone);
    assign busy_o      = (state_q != StIdle);
    assign sum_o       = acc_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_adder_accum.sv
// Self-checking bench for adder_accum: directed vector table, corner-case
// sequences and random transactions against a whole-transaction sum model.
module tb_adder_accum;

    localparam int unsigned SIZE  = 4;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] count;
    logic             in_valid;
    logic [SIZE-1:0]  in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [SIZE-1:0]  sum;
    logic             ovf;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    adder_accum #(
        .SIZE  (SIZE),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .count_i     (count),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .ovf_o       (ovf),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string                name;
        logic [CNT_W-1:0]     cnt;
        logic [15:0][SIZE-1:0] terms;
        int                   gap;
        int                   hold;
        bit                   start_in_done;
        logic [SIZE-1:0]      exp_sum;
        logic                 exp_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string name);
        chk({name, ".in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({name, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({name, ".sum"}, {28'd0, sum}, 32'd0);
        chk({name, ".ovf"}, {31'd0, ovf}, 32'd0);
        chk({name, ".busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_txn(input string name, input logic [CNT_W-1:0] c,
                           input logic [15:0][SIZE-1:0] t, input int gap, input int hold,
                           input bit sid, input logic [SIZE-1:0] es, input logic eo);
        chk({name, ".idle_ready"}, {31'd0, in_ready}, 32'd0);
        chk({name, ".idle_busy"}, {31'd0, busy}, 32'd0);
        start = 1'b1;
        count = c;
        step();
        start = 1'b0;
        count = CNT_W'($urandom);
        chk({name, ".busy_after_start"}, {31'd0, busy}, 32'd1);
        for (int i = 0; i < int'(c); i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_data  = SIZE'($urandom);
                chk({name, ".gap_ready"}, {31'd0, in_ready}, 32'd1);
                step();
            end
            chk({name, ".ready"}, {31'd0, in_ready}, 32'd1);
            in_valid = 1'b1;
            in_data  = t[i];
            step();
            in_valid = 1'b0;
            in_data  = SIZE'($urandom);
            if (i != int'(c) - 1) begin
                chk({name, ".early_valid"}, {31'd0, out_valid}, 32'd0);
            end
        end
        chk({name, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, ".done_ready"}, {31'd0, in_ready}, 32'd0);
        chk({name, ".sum"}, {28'd0, sum}, {28'd0, es});
        chk({name, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            start     = sid && (h == 1);
            in_valid  = sid;
            step();
            start    = 1'b0;
            in_valid = 1'b0;
            chk({name, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({name, ".hold_sum"}, {28'd0, sum}, {28'd0, es});
            chk({name, ".hold_ovf"}, {31'd0, ovf}, {31'd0, eo});
        end
        out_ready = 1'b1;
        start     = sid;
        count     = 4'd3;
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        chk({name, ".back_idle"}, {31'd0, busy}, 32'd0);
        chk({name, ".back_valid"}, {31'd0, out_valid}, 32'd0);
        if (sid) begin
            step();
            chk({name, ".start_not_latched"}, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        logic [15:0][SIZE-1:0] t;
        int                    total;
        logic [CNT_W-1:0]      c;

        rst = 1'b1; start = 1'b0; count = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        vecs[0] = '{"sum9", 4'd3, {52'd0, 4'd4, 4'd3, 4'd2}, 0, 0, 1'b0, 4'd9, 1'b0};
        vecs[1] = '{"wrap", 4'd2, {56'd0, 4'd3, 4'd15}, 0, 0, 1'b0, 4'd2, 1'b1};
        vecs[2] = '{"zero_cnt", 4'd0, 64'd0, 0, 0, 1'b0, 4'd0, 1'b0};
        vecs[3] = '{"gaps", 4'd2, {56'd0, 4'd6, 4'd5}, 3, 0, 1'b0, 4'd11, 1'b0};
        vecs[4] = '{"hold", 4'd2, {56'd0, 4'd9, 4'd8}, 0, 5, 1'b1, 4'd1, 1'b1};
        vecs[5] = '{"max_cnt", 4'd15, {16{4'd15}}, 0, 1, 1'b0, 4'd1, 1'b1};

        step();
        step();
        check_idle_zero("reset");
        rst = 1'b0;
        step();
        check_idle_zero("post_reset");

        foreach (vecs[k]) begin
            run_txn(vecs[k].name, vecs[k].cnt, vecs[k].terms, vecs[k].gap, vecs[k].hold,
                    vecs[k].start_in_done, vecs[k].exp_sum, vecs[k].exp_ovf);
        end

        // Reset after one of three accepted terms.
        start = 1'b1; count = 4'd3;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 4'd9;
        step();
        in_valid = 1'b0;
        chk("mid_rst.acc", {28'd0, sum}, 32'd9);
        rst = 1'b1;
        in_valid = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        check_idle_zero("mid_rst");
        run_txn("after_rst", 4'd1, {60'd0, 4'd7}, 0, 0, 1'b0, 4'd7, 1'b0);

        // Reset in DONE and reset beating start in IDLE.
        start = 1'b1; count = 4'd0;
        step();
        start = 1'b0;
        chk("done_rst.pre", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        step();
        check_idle_zero("done_rst");
        start = 1'b1; count = 4'd2;
        step();
        rst = 1'b0; start = 1'b0;
        check_idle_zero("rst_vs_start");

        // Random transactions: expected result from the full integer total.
        for (int r = 0; r < 25; r++) begin
            c = CNT_W'($urandom_range(0, 15));
            total = 0;
            t = '0;
            for (int i = 0; i < int'(c); i++) begin
                t[i] = SIZE'($urandom);
                total += int'(t[i]);
            end
            run_txn("rand", c, t, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                    bit'($urandom_range(0, 1)), SIZE'(total % (1 << SIZE)),
                    total >= (1 << SIZE));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
